// File: rtl/vga_axil_master_fsm.sv
// AXI-Lite master: converts native single-word write/read requests into AXI-Lite transactions.
// Write and read sides run as independent FSMs; only the sticky error flag is shared.
module vga_axil_master_fsm (
  input  logic        clk,
  input  logic        arst_n,
  // AXI-Lite master side
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // Native request side
  input  logic        write_req_i,
  input  logic [9:0]  addr_write_i,
  input  logic [31:0] data_i,
  output logic        write_ready_o,
  output logic        write_done_o,
  input  logic        read_req_i,
  input  logic [9:0]  addr_read_i,
  output logic        read_ready_o,
  output logic        read_valid_o,
  output logic [31:0] data_o,
  output logic        resp_err_o
);

  typedef enum logic [1:0] {WIdle, WAddrData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [31:0] data_q, data_d;
  logic        write_done_q, write_done_d, read_valid_q, read_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;
  assign b_hs  = bready_q & bvalid;
  assign ar_hs = arvalid_q & arready;
  assign r_hs  = rready_q & rvalid;

  always_comb begin
    w_state_d    = w_state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    write_done_d = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (write_req_i) begin
          awaddr_d  = {20'b0, addr_write_i, 2'b00};
          wdata_d   = data_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = WAddrData;
        end
      end
      WAddrData: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Both channels may finish in the same cycle or in any order.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          bready_d  = 1'b1;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (b_hs) begin
          bready_d     = 1'b0;
          write_done_d = 1'b1;
          w_state_d    = WIdle;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        w_state_d = WIdle;
      end
    endcase
  end

  always_comb begin
    r_state_d    = r_state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    araddr_d     = araddr_q;
    data_d       = data_q;
    read_valid_d = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (read_req_i) begin
          araddr_d  = {20'b0, addr_read_i, 2'b00};
          arvalid_d = 1'b1;
          r_state_d = RAddr;
        end
      end
      RAddr: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = RData;
        end
      end
      RData: begin
        if (r_hs) begin
          data_d       = rdata;
          read_valid_d = 1'b1;
          rready_d     = 1'b0;
          r_state_d    = RIdle;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        r_state_d = RIdle;
      end
    endcase
  end

  assign resp_err_d = resp_err_q | (b_hs & (bresp != 2'b00)) | (r_hs & (rresp != 2'b00));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_state_q    <= WIdle;
      r_state_q    <= RIdle;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      araddr_q     <= '0;
      data_q       <= '0;
      write_done_q <= 1'b0;
      read_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      araddr_q     <= araddr_d;
      data_q       <= data_d;
      write_done_q <= write_done_d;
      read_valid_q <= read_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign awaddr        = awaddr_q;
  assign awvalid       = awvalid_q;
  assign wdata         = wdata_q;
  assign wvalid        = wvalid_q;
  assign bready        = bready_q;
  assign araddr        = araddr_q;
  assign arvalid       = arvalid_q;
  assign rready        = rready_q;
  assign write_ready_o = (w_state_q == WIdle);
  assign read_ready_o  = (r_state_q == RIdle);
  assign write_done_o  = write_done_q;
  assign read_valid_o  = read_valid_q;
  assign data_o        = data_q;
  assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// Testbench for vga_axil_master_fsm: table of write/read transactions against a scripted slave,
// plus hand sequences for concurrency, ignored requests and mid-transaction reset.
module tb_vga_axil_master_fsm;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, rd_data, wr_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        write_req, write_ready, write_done;
  logic        read_req, read_ready, read_valid, resp_err;
  logic [9:0]  addr_write, addr_read;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vga_axil_master_fsm dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .awaddr       (awaddr),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .write_req_i  (write_req),
    .addr_write_i (addr_write),
    .data_i       (wr_data),
    .write_ready_o(write_ready),
    .write_done_o (write_done),
    .read_req_i   (read_req),
    .addr_read_i  (addr_read),
    .read_ready_o (read_ready),
    .read_valid_o (read_valid),
    .data_o       (rd_data),
    .resp_err_o   (resp_err)
  );

  typedef struct {
    bit          is_read;
    logic [9:0]  addr;
    logic [31:0] data;      // write data, or slave rdata for reads
    int          dly_a;     // cycles before awready/arready
    int          dly_w;     // cycles before wready (writes)
    int          dly_r;     // cycles before bvalid/rvalid
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int aw_dly,
                          input int w_dly, input int b_dly, input logic [1:0] br,
                          input logic [31:0] exp_addr);
    bit aw_seen = 0;
    bit w_seen = 0;
    int cyc = 0;
    write_req = 1'b1; addr_write = a; wr_data = d;
    chk("wr_ready_idle", write_ready, 1);
    step();
    write_req = 1'b0;
    while (!(aw_seen && w_seen)) begin
      awready = (cyc >= aw_dly);
      wready  = (cyc >= w_dly);
      chk("awvalid", awvalid, !aw_seen);
      chk("wvalid", wvalid, !w_seen);
      if (!aw_seen) chk("awaddr", awaddr, exp_addr);
      if (!w_seen) chk("wdata", wdata, d);
      chk("bready_early", bready, 0);
      chk("wr_ready_busy", write_ready, 0);
      if (awready) aw_seen = 1;
      if (wready) w_seen = 1;
      step();
      cyc++;
    end
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < b_dly; i++) begin
      chk("bready_wait", bready, 1);
      chk("wr_done_early", write_done, 0);
      step();
    end
    chk("bready", bready, 1);
    chk("aw_w_low", {awvalid, wvalid}, 0);
    bvalid = 1'b1; bresp = br;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("wr_done", write_done, 1);
    chk("wr_ready_back", write_ready, 1);
    chk("bready_clr", bready, 0);
    step();
    chk("wr_done_pulse", write_done, 0);
  endtask

  task automatic do_read(input logic [9:0] a, input int ar_dly, input int r_dly,
                         input logic [31:0] rd, input logic [1:0] rr,
                         input logic [31:0] exp_addr);
    bit seen = 0;
    int cyc = 0;
    read_req = 1'b1; addr_read = a;
    chk("rd_ready_idle", read_ready, 1);
    step();
    read_req = 1'b0;
    while (!seen) begin
      arready = (cyc >= ar_dly);
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, exp_addr);
      chk("rready_early", rready, 0);
      chk("rd_ready_busy", read_ready, 0);
      seen = arready;
      step();
      cyc++;
    end
    arready = 1'b0;
    chk("arvalid_clr", arvalid, 0);
    for (int i = 0; i < r_dly; i++) begin
      chk("rready_wait", rready, 1);
      chk("rd_valid_early", read_valid, 0);
      step();
    end
    chk("rready", rready, 1);
    rvalid = 1'b1; rdata = rd; rresp = rr;
    step();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    chk("rd_valid", read_valid, 1);
    chk("rd_data", rd_data, rd);
    chk("rd_ready_back", read_ready, 1);
    chk("rready_clr", rready, 0);
    step();
    chk("rd_valid_pulse", read_valid, 0);
    chk("rd_data_hold", rd_data, rd);
  endtask

  initial begin
    vecs[0] = '{0, 10'd5,   32'hDEAD_BEEF, 0, 0, 0, 2'b00, 32'h14,  0};
    vecs[1] = '{0, 10'd2,   32'hA5A5_0001, 0, 3, 1, 2'b00, 32'h8,   0};
    vecs[2] = '{1, 10'd3,   32'h1234_5678, 3, 0, 0, 2'b00, 32'hC,   0};
    vecs[3] = '{1, 10'h3FF, 32'hCAFE_F00D, 0, 0, 2, 2'b00, 32'hFFC, 0};
    vecs[4] = '{0, 10'd1,   32'h0000_0001, 2, 0, 0, 2'b10, 32'h4,   1};
    vecs[5] = '{0, 10'd0,   32'hFFFF_FFFF, 0, 0, 0, 2'b00, 32'h0,   1};
    vecs[6] = '{1, 10'd4,   32'h0BAD_CAFE, 0, 0, 0, 2'b00, 32'h10,  1};

    arst_n = 1'b0;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    write_req = 1'b0; read_req = 1'b0;
    addr_write = '0; addr_read = '0; wr_data = '0;
    repeat (3) step();
    arst_n = 1'b1;
    step();
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_readys", {write_ready, read_ready}, 2'b11);
    chk("rst_pulses", {write_done, read_valid}, 0);
    chk("rst_data_o", rd_data, 0);
    chk("rst_addrs", {awaddr, araddr}, 0);
    chk("rst_err", resp_err, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_read)
        do_read(vecs[i].addr, vecs[i].dly_a, vecs[i].dly_r, vecs[i].data, vecs[i].resp,
                vecs[i].exp_addr);
      else
        do_write(vecs[i].addr, vecs[i].data, vecs[i].dly_a, vecs[i].dly_w, vecs[i].dly_r,
                 vecs[i].resp, vecs[i].exp_addr);
      chk("resp_err", resp_err, vecs[i].exp_err);
    end

    // Write and read accepted in the same cycle.
    fork
      do_write(10'd9, 32'h1111_2222, 1, 0, 0, 2'b00, 32'h24);
      do_read(10'd11, 0, 1, 32'h3333_4444, 2'b00, 32'h2C);
    join

    // A second write request while busy must be ignored.
    write_req = 1'b1; addr_write = 10'd7; wr_data = 32'h77;
    step();
    addr_write = 10'd9; wr_data = 32'h99;
    chk("ign_ready", write_ready, 0);
    chk("ign_awaddr0", awaddr, 32'h1C);
    step();
    chk("ign_awaddr1", awaddr, 32'h1C);
    chk("ign_wdata", wdata, 32'h77);
    write_req = 1'b0; awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("ign_bready", bready, 1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("ign_done", write_done, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ign_no_aw", {awvalid, wvalid}, 0);
    end

    // Reset while arvalid is high abandons the read.
    read_req = 1'b1; addr_read = 10'd6;
    step();
    read_req = 1'b0;
    step();
    chk("mr_arvalid_hi", arvalid, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("mr_arvalid_drop", arvalid, 0);
    chk("mr_err_clr", resp_err, 0);
    chk("mr_rd_ready", read_ready, 1);
    step();
    arst_n = 1'b1;
    arready = 1'b1; rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_valid", {read_valid, arvalid, rready}, 0);
    end
    arready = 1'b0; rvalid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
